// File: rtl/kbd_fifo.sv
// kbd_fifo: keyboard receive buffer between the PS/2 controller and the CPU bus.
// Scancode strobes are queued in a circular FIFO. The CPU reads the head byte
// (offset 0) and a status byte (offset 1). Because the bus has no read strobe,
// the CPU pops by writing offset 0, and it clears overflow or flushes by
// writing offset 1.
// Optional feature macro: KBD_BREAK_MERGE_EN. When it is defined, a 0xF0 break
// prefix is folded into a brk bit on the following scancode, and that bit is
// reported as STATUS[3].
module kbd_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic [7:0] PS2_DATA,
  input  logic       PS2_HIT,
  input  logic       SEL,
  input  logic       ADDR,
  input  logic [7:0] WDATA,
  input  logic       WREN,
  output logic [7:0] Q,
  output logic       NOT_EMPTY
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef KBD_BREAK_MERGE_EN
  localparam int ENTRY_W = 9;
`else
  localparam int ENTRY_W = 8;
`endif

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  ovf;

  logic                  empty;
  logic                  full;
  logic                  pop_req;
  logic                  ctrl_wr;
  logic                  flush;
  logic                  ovf_clr;
  logic                  store_req;
  logic                  do_push;
  logic                  do_pop;
  logic                  ovf_set;
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head;
  logic                  brk;
  logic                  unused_wdata;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH[DEPTH_LOG2:0]);
  assign NOT_EMPTY = ~empty;
  assign head      = mem[rptr];

  assign pop_req = SEL & WREN & ~ADDR;
  assign ctrl_wr = SEL & WREN & ADDR;
  assign flush   = ctrl_wr & WDATA[7];
  assign ovf_clr = ctrl_wr & WDATA[2];

  // A pop accepted in the same cycle frees a slot, so a push into a full FIFO
  // still succeeds when it coincides with a pop. Flush drops any same-cycle push.
  assign do_pop  = pop_req & ~empty;
  assign do_push = store_req & (~full | do_pop) & ~flush;
  assign ovf_set = store_req & full & ~do_pop & ~flush;

  // Only the flush and overflow-clear bits of a control write carry meaning.
  assign unused_wdata = ^{WDATA[6:3], WDATA[1:0]};

`ifdef KBD_BREAK_MERGE_EN
  logic pending;
  logic is_break;

  assign is_break   = (PS2_DATA == 8'hF0);
  assign store_req  = PS2_HIT & ~is_break;
  assign push_entry = {pending, PS2_DATA};
  assign brk        = ~empty & head[8];

  // Remember a 0xF0 prefix until the next scancode, which consumes it even when that scancode is lost to overflow.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      pending <= 1'b0;
    end else if (flush) begin
      pending <= 1'b0;
    end else if (PS2_HIT) begin
      pending <= is_break;
    end
  end
`else
  assign store_req  = PS2_HIT;
  assign push_entry = PS2_DATA;
  assign brk        = 1'b0;
`endif

  // Storage is never reset; its contents are only visible when count says an entry is valid.
  always_ff @(posedge CLOCK) begin
    if (do_push) begin
      mem[wptr] <= push_entry;
    end
  end

  // Pointers and occupancy: flush clears everything, otherwise push and pop move independently.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + DEPTH_LOG2'(1);
      end
      if (do_pop) begin
        rptr <= rptr + DEPTH_LOG2'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (DEPTH_LOG2 + 1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (DEPTH_LOG2 + 1)'(1);
      end
    end
  end

  // Sticky overflow flag; a same-cycle clear beats a same-cycle set.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      ovf <= 1'b0;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end
  end

  // Register read mux: the head byte reads as zero when the FIFO is empty.
  always_comb begin
    Q = 8'h00;
    if (ADDR) begin
      Q = {4'b0000, brk, ovf, full, ~empty};
    end else if (!empty) begin
      Q = head[7:0];
    end
  end

endmodule

// File: tb/tb_kbd_fifo.sv
// tb_kbd_fifo: directed and randomized checks of kbd_fifo against a queue-based
// model of the receive buffer.
module tb_kbd_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic       CLOCK;
  logic       RESET_N;
  logic [7:0] PS2_DATA;
  logic       PS2_HIT;
  logic       SEL;
  logic       ADDR;
  logic [7:0] WDATA;
  logic       WREN;
  logic [7:0] Q;
  logic       NOT_EMPTY;

  int numChecks = 0;
  int numFail   = 0;

  logic [8:0] mq[$];
  logic       ovfM  = 1'b0;
  logic       pendM = 1'b0;

  kbd_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .PS2_DATA  (PS2_DATA),
    .PS2_HIT   (PS2_HIT),
    .SEL       (SEL),
    .ADDR      (ADDR),
    .WDATA     (WDATA),
    .WREN      (WREN),
    .Q         (Q),
    .NOT_EMPTY (NOT_EMPTY)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    numChecks++;
    assert (obs === exp)
    else begin
      numFail++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic readReg(input logic a, output logic [7:0] v);
    ADDR = a;
    #1;
    v = Q;
  endtask

  // Model: a received byte is kept unless the buffer is already full.
  task automatic storeM(input logic [7:0] d);
    if (mq.size() < DEPTH) mq.push_back({pendM, d});
    else ovfM = 1'b1;
    pendM = 1'b0;
  endtask

  task automatic modelStep(input logic hit, input logic [7:0] d, input logic sel,
                           input logic wren, input logic addr, input logic [7:0] wd);
    logic pop, ctrl;
    pop  = sel && wren && !addr;
    ctrl = sel && wren && addr;
    if (ctrl && wd[7]) begin
      mq.delete();
      pendM = 1'b0;
    end else begin
      if (pop && mq.size() > 0) void'(mq.pop_front());
      if (hit) begin
`ifdef KBD_BREAK_MERGE_EN
        if (d == 8'hF0) pendM = 1'b1;
        else storeM(d);
`else
        storeM(d);
`endif
      end
    end
    if (ctrl && wd[2]) ovfM = 1'b0;
  endtask

  // One bus cycle: inputs are driven after the falling edge and released 1 ns after the rising edge.
  task automatic applyStimulus(input logic hit, input logic [7:0] d, input logic sel,
                               input logic wren, input logic addr, input logic [7:0] wd);
    @(negedge CLOCK);
    PS2_HIT  = hit;
    PS2_DATA = d;
    SEL      = sel;
    WREN     = wren;
    ADDR     = addr;
    WDATA    = wd;
    @(posedge CLOCK);
    #1;
    PS2_HIT = 1'b0;
    SEL     = 1'b0;
    WREN    = 1'b0;
    modelStep(hit, d, sel, wren, addr, wd);
  endtask

  task automatic pushByte(input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic popByte();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF);
  endtask

  task automatic ctrlWrite(input logic [7:0] wd);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, wd);
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] v;
    logic [7:0] expHead;
    logic [7:0] expStat;
    logic       brkM;
    expHead = (mq.size() != 0) ? mq[0][7:0] : 8'h00;
`ifdef KBD_BREAK_MERGE_EN
    brkM = (mq.size() != 0) ? mq[0][8] : 1'b0;
`else
    brkM = 1'b0;
`endif
    expStat = {4'b0000, brkM, ovfM, mq.size() == DEPTH, mq.size() != 0};
    readReg(1'b0, v);
    checkValue({tag, ".data"}, v, expHead);
    readReg(1'b1, v);
    checkValue({tag, ".status"}, v, expStat);
    checkValue({tag, ".ne"}, {7'b0, NOT_EMPTY}, {7'b0, mq.size() != 0});
  endtask

  initial begin
    logic [7:0] v;
    logic       hit, sel, wren, addr;
    logic [7:0] d, wd;

    RESET_N  = 1'b0;
    PS2_HIT  = 1'b0;
    PS2_DATA = 8'h00;
    SEL      = 1'b0;
    WREN     = 1'b0;
    ADDR     = 1'b0;
    WDATA    = 8'h00;
    repeat (2) @(posedge CLOCK);
    #1;
    readReg(1'b0, v); checkValue("reset.data", v, 8'h00);
    readReg(1'b1, v); checkValue("reset.status", v, 8'h00);
    checkValue("reset.ne", {7'b0, NOT_EMPTY}, 8'h00);
    @(negedge CLOCK);
    RESET_N = 1'b1;

    // Single push, then pop it.
    pushByte(8'h1C);
    readReg(1'b0, v); checkValue("first.data", v, 8'h1C);
    readReg(1'b1, v); checkValue("first.status", v, 8'h01);
    checkOutput("first");
    popByte();
    checkOutput("first_pop");
    readReg(1'b0, v); checkValue("first_pop.data0", v, 8'h00);

    // Fill to full, overflow, then drain in order.
    for (int i = 0; i < DEPTH; i++) pushByte(8'(i));
    readReg(1'b1, v); checkValue("full.status", v, 8'h03);
    pushByte(8'h55);
    readReg(1'b1, v); checkValue("ovf.status", v, 8'h07);
    checkOutput("ovf");
    for (int i = 0; i < DEPTH; i++) begin
      readReg(1'b0, v); checkValue("drain.order", v, 8'(i));
      popByte();
    end
    checkOutput("drained");
    ctrlWrite(8'h04);
    readReg(1'b1, v); checkValue("ovf_clear.status", v, 8'h00);

    // Wrap-around of the pointers.
    for (int i = 0; i < 10; i++) pushByte(8'(8'h10 + i));
    for (int i = 0; i < 10; i++) popByte();
    for (int i = 0; i < 10; i++) pushByte(8'(8'hA0 + i));
    checkOutput("wrap");
    for (int i = 0; i < 10; i++) begin
      readReg(1'b0, v); checkValue("wrap.order", v, 8'(8'hA0 + i));
      popByte();
    end
    checkOutput("wrap_done");

    // Full FIFO with a same-cycle push and pop.
    for (int i = 0; i < DEPTH; i++) pushByte(8'(8'h30 + i));
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 8'h00);
    readReg(1'b1, v); checkValue("full_pushpop.status", v, 8'h03);
    checkOutput("full_pushpop");
    for (int i = 0; i < DEPTH; i++) begin
      readReg(1'b0, v);
      if (i == DEPTH - 1) checkValue("full_pushpop.last", v, 8'h77);
      else checkValue("full_pushpop.order", v, 8'(8'h31 + i));
      popByte();
    end
    checkOutput("full_pushpop_done");

    // Flush with a same-cycle push.
    pushByte(8'h01); pushByte(8'h02); pushByte(8'h03);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b1, 1'b1, 8'h80);
    readReg(1'b1, v); checkValue("flush.status", v, 8'h00);
    checkOutput("flush");

    // Asynchronous reset in the middle of a cycle.
    pushByte(8'h42); pushByte(8'h43);
    #1;
    RESET_N = 1'b0;
    mq.delete(); ovfM = 1'b0; pendM = 1'b0;
    readReg(1'b0, v); checkValue("async_reset.data", v, 8'h00);
    readReg(1'b1, v); checkValue("async_reset.status", v, 8'h00);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    checkOutput("after_reset");

`ifdef KBD_BREAK_MERGE_EN
    // Break prefix merging.
    pushByte(8'hF0); pushByte(8'h1C); pushByte(8'h1C);
    readReg(1'b0, v); checkValue("brk.first.data", v, 8'h1C);
    readReg(1'b1, v); checkValue("brk.first.status", v, 8'h09);
    popByte();
    readReg(1'b0, v); checkValue("brk.second.data", v, 8'h1C);
    readReg(1'b1, v); checkValue("brk.second.status", v, 8'h01);
    popByte();
    checkOutput("brk_done");
`endif

    // Randomized traffic: push-heavy first to reach full and overflow, then balanced.
    for (int n = 0; n < 600; n++) begin
      hit  = (n < 150) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 5);
      sel  = (n < 150) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
      wren = ($urandom_range(0, 3) != 0);
      addr = ($urandom_range(0, 7) == 0);
      d    = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'hF0;
      wd    = 8'($urandom);
      wd[7] = ($urandom_range(0, 9) == 0);
      applyStimulus(hit, d, sel, wren, addr, wd);
      checkOutput("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFail);
    $finish;
  end

endmodule
